csc_stream: RTL and testbench

//  Parametrised 3-channel colour-space converter; next generation of RGB2YCbCr.

---
 rtl/csc_stream.sv | 197 +++++++++++++++++++
 tb/tb_csc_stream.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/csc_stream.sv
// csc_stream: 3-stage pipelined RGB->YCbCr converter (BT.601 / BT.709 / bypass) with valid/ready.
// Optional per-frame clip/pixel statistics are built when the CSC_STATS_EN macro is defined.
module csc_stream #(
  parameter int DATA_W    = 10,
  parameter int COEF_FRAC = 12,
  parameter int CNT_W     = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            mode,
  input  logic [3*DATA_W-1:0]   in_data,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3*DATA_W-1:0]   out_data,
  output logic                  out_sof,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef CSC_STATS_EN
  ,
  output logic [CNT_W-1:0]      clip_cnt,
  output logic [CNT_W-1:0]      pix_cnt
`endif
);

  localparam int CW = COEF_FRAC + 2;
  localparam int AW = DATA_W + COEF_FRAC + 3;
  localparam logic signed [AW-1:0] RND  = AW'(2 ** (COEF_FRAC - 1));
  localparam logic signed [AW-1:0] OFF  = AW'(2 ** (DATA_W - 1));
  localparam logic signed [AW-1:0] MAXV = AW'(2 ** DATA_W - 1);

  // Coefficients are tabulated at 12 fractional bits and rescaled (round half up) to COEF_FRAC.
  function automatic logic signed [CW-1:0] scale(input int c);
    int v;
    if (COEF_FRAC >= 12) v = c <<< (COEF_FRAC - 12);
    else v = (c + (1 <<< (11 - COEF_FRAC))) >>> (12 - COEF_FRAC);
    return CW'(v);
  endfunction

  function automatic logic signed [CW-1:0] coef(input logic sel709, input int idx);
    int c;
    case (idx)
      0:       c = sel709 ? 871   : 1225;
      1:       c = sel709 ? 2929  : 2404;
      2:       c = sel709 ? 296   : 467;
      3:       c = sel709 ? -469  : -691;
      4:       c = sel709 ? -1579 : -1357;
      5:       c = 2048;
      6:       c = 2048;
      7:       c = sel709 ? -1860 : -1715;
      8:       c = sel709 ? -188  : -333;
      default: c = 0;
    endcase
    return scale(c);
  endfunction

  logic                  w_adv;
  logic [1:0]            w_pix_mode;
  logic                  w_sel709;
  logic signed [AW-1:0]  w_prod [9];

  logic [1:0]            r_mode;
  logic                  r_s1_vld, r_s1_sof;
  logic [1:0]            r_s1_mode;
  logic [3*DATA_W-1:0]   r_s1_data;
  logic signed [AW-1:0]  r_s1_prod [9];
  logic                  r_s2_vld, r_s2_sof;
  logic [1:0]            r_s2_mode;
  logic [3*DATA_W-1:0]   r_s2_data;
  logic signed [AW-1:0]  r_s2_sum [3];
  logic                  r_out_vld, r_out_sof;
  logic [3*DATA_W-1:0]   r_out_data;

  logic signed [AW-1:0]  w_rnd [3];
  logic signed [AW-1:0]  w_sh  [3];
  logic signed [AW-1:0]  w_off [3];
  logic [2:0]            w_neg, w_hi;
  logic [3*DATA_W-1:0]   w_res;

  assign w_adv     = ~r_out_vld | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_out_vld;
  assign out_sof   = r_out_sof;
  assign out_data  = r_out_data;

  // A SOF beat uses the incoming mode immediately; other beats use the latched frame mode.
  always_comb begin
    w_pix_mode = in_sof ? mode : r_mode;
    w_sel709   = (w_pix_mode == 2'd1);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_prod[r*3+c] = AW'(coef(w_sel709, r*3+c)) *
                        AW'($signed({1'b0, in_data[c*DATA_W +: DATA_W]}));
      end
    end
  end

  always_comb begin
    w_res = '0;
    w_neg = '0;
    w_hi  = '0;
    for (int r = 0; r < 3; r++) begin
      w_rnd[r] = r_s2_sum[r] + RND;
      w_sh[r]  = w_rnd[r] >>> COEF_FRAC;
      w_off[r] = (r == 0) ? w_sh[r] : w_sh[r] + OFF;
      w_neg[r] = w_off[r][AW-1];
      w_hi[r]  = !w_off[r][AW-1] && (w_off[r] > MAXV);
      if (r_s2_mode[1])
        w_res[r*DATA_W +: DATA_W] = r_s2_data[r*DATA_W +: DATA_W];
      else if (w_neg[r])
        w_res[r*DATA_W +: DATA_W] = '0;
      else if (w_hi[r])
        w_res[r*DATA_W +: DATA_W] = '1;
      else
        w_res[r*DATA_W +: DATA_W] = w_off[r][DATA_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode     <= 2'd0;
      r_s1_vld   <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_mode  <= 2'd0;
      r_s1_data  <= '0;
      r_s2_vld   <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_mode  <= 2'd0;
      r_s2_data  <= '0;
      r_out_vld  <= 1'b0;
      r_out_sof  <= 1'b0;
      r_out_data <= '0;
      for (int i = 0; i < 9; i++) r_s1_prod[i] <= '0;
      for (int i = 0; i < 3; i++) r_s2_sum[i] <= '0;
    end else if (w_adv) begin
      if (in_valid && in_sof) r_mode <= mode;
      r_s1_vld  <= in_valid;
      r_s1_sof  <= in_valid & in_sof;
      r_s1_mode <= w_pix_mode;
      r_s1_data <= in_data;
      for (int i = 0; i < 9; i++) r_s1_prod[i] <= w_prod[i];
      r_s2_vld  <= r_s1_vld;
      r_s2_sof  <= r_s1_sof;
      r_s2_mode <= r_s1_mode;
      r_s2_data <= r_s1_data;
      for (int i = 0; i < 3; i++)
        r_s2_sum[i] <= r_s1_prod[3*i] + r_s1_prod[3*i+1] + r_s1_prod[3*i+2];
      r_out_vld <= r_s2_vld;
      r_out_sof <= r_s2_vld & r_s2_sof;
      if (r_s2_vld) r_out_data <= w_res;
    end
  end

`ifdef CSC_STATS_EN
  logic [2:0]       r_out_clip;
  logic [1:0]       w_clip_n;
  logic             w_beat;
  logic [CNT_W-1:0] r_clip_acc, r_pix_acc, r_clip_q, r_pix_q;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign w_beat   = r_out_vld & out_ready;
  assign w_clip_n = {1'b0, r_out_clip[0]} + {1'b0, r_out_clip[1]} + {1'b0, r_out_clip[2]};
  assign clip_cnt = r_clip_q;
  assign pix_cnt  = r_pix_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_clip <= 3'b0;
      r_clip_acc <= '0;
      r_pix_acc  <= '0;
      r_clip_q   <= '0;
      r_pix_q    <= '0;
    end else begin
      if (w_adv)
        r_out_clip <= (r_s2_vld && !r_s2_mode[1]) ? (w_neg | w_hi) : 3'b0;
      // The SOF beat closes the previous frame and opens the new one with itself.
      if (w_beat) begin
        if (r_out_sof) begin
          r_clip_q   <= r_clip_acc;
          r_pix_q    <= r_pix_acc;
          r_clip_acc <= CNT_W'(w_clip_n);
          r_pix_acc  <= CNT_W'(1);
        end else begin
          r_clip_acc <= sat_add(r_clip_acc, w_clip_n);
          r_pix_acc  <= sat_add(r_pix_acc, 2'd1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_csc_stream.sv
// Directed self-checking bench for csc_stream: conversion values, latency, stall/hold, mode latching, reset.
module tb_csc_stream;
  localparam int DW = 10;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      mode;
  logic [3*DW-1:0] in_data;
  logic            in_sof, in_valid, in_ready;
  logic [3*DW-1:0] out_data;
  logic            out_sof, out_valid, out_ready;
`ifdef CSC_STATS_EN
  logic [23:0]     clip_cnt, pix_cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [3*DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  csc_stream dut (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_sof(out_sof),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef CSC_STATS_EN
    , .clip_cnt(clip_cnt), .pix_cnt(pix_cnt)
`endif
  );

  function automatic logic [3*DW-1:0] pk(input int a, input int b, input int c);
    return {c[DW-1:0], b[DW-1:0], a[DW-1:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One pixel in, then verify exact 3-clock latency and the converted triple.
  task automatic px(input string tag, input int r, input int g, input int b, input logic sof,
                    input logic [1:0] md, input int ey, input int ecb, input int ecr);
    @(negedge clk);
    in_data = pk(r, g, b); in_sof = sof; mode = md; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0;
    chk({tag, "_vld1"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_vld2"}, 32'(out_valid), 0);
    @(negedge clk);
    chk({tag, "_vld3"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(pk(ey, ecb, ecr)));
    chk({tag, "_sof"},  32'(out_sof), 32'(sof));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int sent, got;
    logic [3*DW-1:0] held;
    rst = 1'b1; mode = 2'd0; in_data = '0; in_sof = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_vld",   32'(out_valid), 0);
    chk("rst_sof",   32'(out_sof), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_ready", 32'(in_ready), 1);
`ifdef CSC_STATS_EN
    chk("rst_clip", 32'(clip_cnt), 0);
    chk("rst_pix",  32'(pix_cnt), 0);
`endif

    // Frame A (BT601): black, white, red (Cr clamps high), then a mid-frame mode change.
    px("t1_black", 0, 0, 0, 1'b1, 2'd0, 0, 512, 512);
    px("t2_white", 1023, 1023, 1023, 1'b0, 2'd0, 1023, 512, 512);
    px("t2_red",   1023, 0, 0, 1'b0, 2'd0, 306, 339, 1023);
    px("t4_mid",   0, 1023, 0, 1'b0, 2'd1, 600, 173, 84);
    // Frame B: SOF latches BT709; later mode input is ignored.
    px("t4_sof",   1023, 1023, 1023, 1'b1, 2'd1, 1023, 512, 512);
    @(negedge clk);
`ifdef CSC_STATS_EN
    chk("t4_clip_cnt", 32'(clip_cnt), 1);
    chk("t4_pix_cnt",  32'(pix_cnt), 4);
`endif
    px("t4_green", 0, 1023, 0, 1'b0, 2'd0, 732, 118, 47);

    // Bypass
    px("t5_bypass", 0, 40, 80, 1'b1, 2'd2, 0, 40, 80);

    // Streaming bypass frame with a 5-cycle downstream stall.
    sent = 0; got = 0; held = '0;
    for (int c = 0; c < 80 && got < 20; c++) begin
      @(negedge clk);
      out_ready = !(c >= 5 && c <= 9);
      in_valid  = (sent < 20);
      in_sof    = (sent == 0);
      mode      = 2'd2;
      in_data   = pk(sent + 1, 2 * sent + 100, 1023 - sent);
      #1;
      if (c >= 5 && c <= 9) begin
        chk("t3_in_ready", 32'(in_ready), 0);
        chk("t3_out_vld",  32'(out_valid), 1);
        if (c == 5) held = out_data;
        else chk("t3_hold", 32'(out_data), 32'(held));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("t3_extra", 1, 0);
        else chk("t3_data", 32'(out_data), 32'(exp_q.pop_front()));
        got++;
      end
    end
    in_valid = 1'b0; in_sof = 1'b0;
    chk("t3_count", 32'(got), 20);
    chk("t3_q_empty", 32'(exp_q.size()), 0);

    // Reset with three pixels in flight; SOF with BT709 so reset must restore BT601.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; in_sof = 1'b1; mode = 2'd1; in_data = pk(1023, 0, 0);
    @(negedge clk);
    in_sof = 1'b0; in_data = pk(5, 6, 7);
    @(negedge clk);
    in_data = pk(8, 9, 10);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_vld",   32'(out_valid), 0);
    chk("t6_data",  32'(out_data), 0);
    chk("t6_ready", 32'(in_ready), 1);
`ifdef CSC_STATS_EN
    chk("t6_clip_cnt", 32'(clip_cnt), 0);
    chk("t6_pix_cnt",  32'(pix_cnt), 0);
`endif
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_no_stale", 32'(out_valid), 0);
    end
    px("t6_mode601", 0, 1023, 0, 1'b0, 2'd1, 600, 173, 84);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
